// File: rtl/sdi_xcvr_pkg.sv
// Shared types and constants for the SDI transceiver lane adapter.
package sdi_xcvr_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      QUALIFY  = 2'd1,
      LOCKED   = 2'd2
   } lock_state_t;

   localparam int unsigned LOL_W = 8;
   localparam logic [LOL_W-1:0] LOL_MAX = '1;

endpackage : sdi_xcvr_pkg

// File: rtl/sdi_xcvr_lane_adapter_if.sv
// Bundle of core-side and PHY-side lane signals for the lane adapter.
interface sdi_xcvr_lane_adapter_if
   import sdi_xcvr_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = 64
);
   logic [NUM_CH*DATA_W-1:0] tx_data_a;
   logic [NUM_CH-1:0]        tx_en;
   logic [NUM_CH*DATA_W-1:0] tx_parallel_data;
   logic [NUM_CH*DATA_W-1:0] rx_parallel_data;
   logic [NUM_CH-1:0]        rx_is_lockedtodata;
   logic [NUM_CH*DATA_W-1:0] rx_data_a;
   logic [NUM_CH-1:0]        rx_valid_a;
   logic [NUM_CH*LOL_W-1:0]  lol_count;
   logic                     lol_clear;
   logic                     test_reset_n_a;

   // Environment side: core and PHY models driving the adapter.
   modport master (
      output tx_data_a, tx_en, rx_parallel_data, rx_is_lockedtodata, lol_clear,
      input  tx_parallel_data, rx_data_a, rx_valid_a, lol_count, test_reset_n_a
   );

   // Adapter side.
   modport slave (
      input  tx_data_a, tx_en, rx_parallel_data, rx_is_lockedtodata, lol_clear,
      output tx_parallel_data, rx_data_a, rx_valid_a, lol_count, test_reset_n_a
   );
endinterface : sdi_xcvr_lane_adapter_if

// File: rtl/sdi_lock_qualifier.sv
// Per-lane CDR lock debounce FSM, loss-of-lock counter and RX data register.
module sdi_lock_qualifier
   import sdi_xcvr_pkg::*;
#(
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned LOCK_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_lock,
   input  logic [DATA_W-1:0] i_rx_data,
   input  logic              i_lol_clear,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   output logic [LOL_W-1:0]  o_lol_count
);
   localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   lock_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_qcnt, w_qcnt_nxt;
   logic [LOL_W-1:0]  r_lol, w_lol_nxt;
   logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
   logic              w_lol_event;

   // State, counters and RX data register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= UNLOCKED;
         r_qcnt    <= '0;
         r_lol     <= '0;
         r_rx_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_qcnt    <= w_qcnt_nxt;
         r_lol     <= w_lol_nxt;
         r_rx_data <= w_rx_data_nxt;
      end
   end

   // Next-state, qualify counter, saturating lol counter and RX data gating.
   always_comb begin
      w_state_nxt   = r_state;
      w_qcnt_nxt    = r_qcnt;
      w_lol_event   = 1'b0;
      w_lol_nxt     = r_lol;
      w_rx_data_nxt = '0;

      case (r_state)
         UNLOCKED: begin
            if (i_lock) begin
               w_state_nxt = QUALIFY;
               w_qcnt_nxt  = '0;
            end
         end
         QUALIFY: begin
            if (!i_lock) begin
               w_state_nxt = UNLOCKED;
            end else if (r_qcnt == CNT_W'(LOCK_CYCLES - 1)) begin
               w_state_nxt = LOCKED;
            end else begin
               w_qcnt_nxt = r_qcnt + CNT_W'(1);
            end
         end
         LOCKED: begin
            if (!i_lock) begin
               w_state_nxt = UNLOCKED;
               w_lol_event = 1'b1;
            end
         end
         default: w_state_nxt = UNLOCKED;
      endcase

      // A clear coinciding with a new loss keeps that loss counted.
      if (i_lol_clear) begin
         w_lol_nxt = w_lol_event ? LOL_W'(1) : '0;
      end else if (w_lol_event && (r_lol != LOL_MAX)) begin
         w_lol_nxt = r_lol + LOL_W'(1);
      end

      if (w_state_nxt == LOCKED) begin
         w_rx_data_nxt = i_rx_data;
      end
   end

   assign o_rx_data   = r_rx_data;
   assign o_rx_valid  = (r_state == LOCKED);
   assign o_lol_count = r_lol;

endmodule : sdi_lock_qualifier

// File: rtl/sdi_xcvr_lane_adapter.sv
// Multi-lane adapter between transceiver PHY parallel ports and SDI core.
module sdi_xcvr_lane_adapter
   import sdi_xcvr_pkg::*;
#(
   parameter int unsigned     NUM_CH      = 4,
   parameter int unsigned     DATA_W      = 64,
   parameter int unsigned     LOCK_CYCLES = 1024,
   parameter int unsigned     RST_CYCLES  = 256,
   parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   sdi_xcvr_lane_adapter_if.slave  bus
);
   localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

   logic [NUM_CH*DATA_W-1:0] r_tx_data;
   logic [RST_W-1:0]         r_rst_cnt;
   logic                     r_test_rst_n;
   logic [NUM_CH*DATA_W-1:0] w_rx_data;
   logic [NUM_CH-1:0]        w_rx_valid;
   logic [NUM_CH*LOL_W-1:0]  w_lol_count;

   // Stretched test reset: count down after reset release, then release.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rst_cnt    <= RST_W'(RST_CYCLES);
         r_test_rst_n <= 1'b0;
      end else begin
         if (r_rst_cnt != '0) begin
            r_rst_cnt <= r_rst_cnt - RST_W'(1);
         end
         r_test_rst_n <= (r_rst_cnt == '0);
      end
   end

   // TX register with idle substitution for disabled lanes or test reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset) begin
            r_tx_data[i*DATA_W +: DATA_W] <= IDLE_WORD;
         end else if (bus.tx_en[i] && r_test_rst_n) begin
            r_tx_data[i*DATA_W +: DATA_W] <= bus.tx_data_a[i*DATA_W +: DATA_W];
         end else begin
            r_tx_data[i*DATA_W +: DATA_W] <= IDLE_WORD;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      sdi_lock_qualifier #(
         .DATA_W      (DATA_W),
         .LOCK_CYCLES (LOCK_CYCLES)
      ) u_lock_qual (
         .clk         (clk),
         .reset       (reset),
         .i_lock      (bus.rx_is_lockedtodata[g]),
         .i_rx_data   (bus.rx_parallel_data[g*DATA_W +: DATA_W]),
         .i_lol_clear (bus.lol_clear),
         .o_rx_data   (w_rx_data[g*DATA_W +: DATA_W]),
         .o_rx_valid  (w_rx_valid[g]),
         .o_lol_count (w_lol_count[g*LOL_W +: LOL_W])
      );
   end

   assign bus.tx_parallel_data = r_tx_data;
   assign bus.rx_data_a        = w_rx_data;
   assign bus.rx_valid_a       = w_rx_valid;
   assign bus.lol_count        = w_lol_count;
   assign bus.test_reset_n_a   = r_test_rst_n;

endmodule : sdi_xcvr_lane_adapter

// File: tb/tb_sdi_xcvr_lane_adapter.sv
// Directed self-checking bench for sdi_xcvr_lane_adapter (2 lanes, 64-bit).
module tb_sdi_xcvr_lane_adapter;
   localparam int unsigned NUM_CH      = 2;
   localparam int unsigned DATA_W      = 64;
   localparam int unsigned LOCK_CYCLES = 8;
   localparam int unsigned RST_CYCLES  = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   sdi_xcvr_lane_adapter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) u_if ();

   sdi_xcvr_lane_adapter #(
      .NUM_CH      (NUM_CH),
      .DATA_W      (DATA_W),
      .LOCK_CYCLES (LOCK_CYCLES),
      .RST_CYCLES  (RST_CYCLES),
      .IDLE_WORD   (64'h0)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance one clock edge; inputs are driven and outputs sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      u_if.tx_data_a          = '0;
      u_if.tx_en              = '0;
      u_if.rx_parallel_data   = '0;
      u_if.rx_is_lockedtodata = '0;
      u_if.lol_clear          = 1'b0;

      // Reset state.
      repeat (3) tick();
      check_eq("rst_tx0",   64'(u_if.tx_parallel_data[63:0]), 64'h0);
      check_eq("rst_tx1",   64'(u_if.tx_parallel_data[127:64]), 64'h0);
      check_eq("rst_valid", 64'(u_if.rx_valid_a), 64'h0);
      check_eq("rst_rx",    64'(u_if.rx_data_a[63:0] | u_if.rx_data_a[127:64]), 64'h0);
      check_eq("rst_lol",   64'(u_if.lol_count), 64'h0);
      check_eq("rst_trn",   64'(u_if.test_reset_n_a), 64'h0);

      // Reset release: test reset rises on the 5th edge; TX idle until then.
      u_if.tx_en = 2'b01;
      u_if.tx_data_a[63:0]   = 64'hA5A5_A5A5_A5A5_A5A5;
      u_if.tx_data_a[127:64] = 64'h5A5A_5A5A_5A5A_5A5A;
      u_if.rx_parallel_data[127:64] = 64'hDEAD_BEEF_0000_0001;
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check_eq($sformatf("trn_e%0d", k), 64'(u_if.test_reset_n_a), (k == 5) ? 64'h1 : 64'h0);
         check_eq($sformatf("tx0_idle_e%0d", k), 64'(u_if.tx_parallel_data[63:0]), 64'h0);
      end
      tick();
      check_eq("tx0_data", 64'(u_if.tx_parallel_data[63:0]), 64'hA5A5_A5A5_A5A5_A5A5);
      check_eq("tx1_idle", 64'(u_if.tx_parallel_data[127:64]), 64'h0);
      u_if.tx_data_a[63:0] = 64'h0123_4567_89AB_CDEF;
      tick();
      check_eq("tx0_lat1", 64'(u_if.tx_parallel_data[63:0]), 64'h0123_4567_89AB_CDEF);

      // Qualification on lane0: valid after the 8th edge following E0.
      u_if.rx_is_lockedtodata[0] = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         u_if.rx_parallel_data[63:0] = 64'(100 + k);
         tick();
         check_eq($sformatf("q_valid0_e%0d", k), 64'(u_if.rx_valid_a[0]), (k >= 8) ? 64'h1 : 64'h0);
         check_eq($sformatf("q_rx0_e%0d", k), 64'(u_if.rx_data_a[63:0]), (k >= 8) ? 64'(100 + k) : 64'h0);
         check_eq($sformatf("q_valid1_e%0d", k), 64'(u_if.rx_valid_a[1]), 64'h0);
         check_eq($sformatf("q_rx1_e%0d", k), 64'(u_if.rx_data_a[127:64]), 64'h0);
      end

      // Abort on lane1: 5 high, 1 low, then a full 9 sampled-high edges.
      for (int k = 0; k <= 14; k++) begin
         u_if.rx_is_lockedtodata[1] = (k != 5);
         tick();
         check_eq($sformatf("ab_valid1_e%0d", k), 64'(u_if.rx_valid_a[1]), (k == 14) ? 64'h1 : 64'h0);
      end
      check_eq("ab_rx1", 64'(u_if.rx_data_a[127:64]), 64'hDEAD_BEEF_0000_0001);
      check_eq("ab_lol1", 64'(u_if.lol_count[15:8]), 64'h0);

      // Loss of lock on lane0.
      u_if.rx_is_lockedtodata[0] = 1'b0;
      tick();
      check_eq("lol_valid0", 64'(u_if.rx_valid_a[0]), 64'h0);
      check_eq("lol_rx0", 64'(u_if.rx_data_a[63:0]), 64'h0);
      check_eq("lol_cnt0_1", 64'(u_if.lol_count[7:0]), 64'h1);
      for (int n = 2; n <= 300; n++) begin
         u_if.rx_is_lockedtodata[0] = 1'b1;
         repeat (9) tick();
         if (n == 300) check_eq("lol_relock0", 64'(u_if.rx_valid_a[0]), 64'h1);
         u_if.rx_is_lockedtodata[0] = 1'b0;
         tick();
         if (n == 2) check_eq("lol_cnt0_2", 64'(u_if.lol_count[7:0]), 64'h2);
      end
      check_eq("lol_cnt0_sat", 64'(u_if.lol_count[7:0]), 64'd255);

      // Relock lane0, then clear on the same edge as a lane1 loss.
      u_if.rx_is_lockedtodata[0] = 1'b1;
      repeat (9) tick();
      check_eq("relock_valid0", 64'(u_if.rx_valid_a[0]), 64'h1);
      u_if.rx_is_lockedtodata[1] = 1'b0;
      u_if.lol_clear = 1'b1;
      tick();
      check_eq("clr_lol1", 64'(u_if.lol_count[15:8]), 64'h1);
      check_eq("clr_lol0", 64'(u_if.lol_count[7:0]), 64'h0);
      u_if.lol_clear = 1'b0;
      tick();
      check_eq("clr_hold1", 64'(u_if.lol_count[15:8]), 64'h1);

      // Reset while lane0 is LOCKED.
      u_if.rx_parallel_data[63:0] = 64'hCAFE;
      reset = 1'b1;
      tick();
      check_eq("mid_valid", 64'(u_if.rx_valid_a), 64'h0);
      check_eq("mid_rx0", 64'(u_if.rx_data_a[63:0]), 64'h0);
      check_eq("mid_lol", 64'(u_if.lol_count), 64'h0);
      check_eq("mid_trn", 64'(u_if.test_reset_n_a), 64'h0);
      check_eq("mid_tx0", 64'(u_if.tx_parallel_data[63:0]), 64'h0);
      reset = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         tick();
         check_eq($sformatf("rq_valid0_e%0d", k), 64'(u_if.rx_valid_a[0]), (k == 8) ? 64'h1 : 64'h0);
      end
      check_eq("rq_rx0", 64'(u_if.rx_data_a[63:0]), 64'hCAFE);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule : tb_sdi_xcvr_lane_adapter
